// File: rtl/avalon_mem_bridge_pkg.sv
// Shared state type, limits and burst-length helper for the Avalon burst bridge.
package avalon_mem_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN
    } state_e;

    localparam int MAX_BURST_DEF  = 8;
    localparam int RD_LATENCY_MAX = 4;

    function automatic logic [3:0] sat_burst(
        input logic [3:0] bc,
        input int         max_burst
    );
        logic [3:0] n;
        if (bc == 4'd0) begin
            n = 4'd1;
        end else if (int'(bc) > max_burst) begin
            n = 4'(max_burst);
        end else begin
            n = bc;
        end
        return n;
    endfunction

endpackage

// File: rtl/avalon_rd_latency_pipe.sv
// Valid shift register matching the backend read latency.
// empty: nothing would remain in flight after this cycle's shift.
module avalon_rd_latency_pipe #(
    parameter int RD_LATENCY = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic valid,
    output logic empty
);

    logic [RD_LATENCY-1:0] v_q;
    logic [RD_LATENCY-1:0] v_d;

    always_comb begin
        v_d    = '0;
        v_d[0] = load;
        for (int i = 1; i < RD_LATENCY; i++) begin
            v_d[i] = v_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v_q <= '0;
        end else begin
            v_q <= v_d;
        end
    end

    assign valid = v_q[RD_LATENCY-1];

    // The tail leaves this cycle, so only the younger stages matter.
    always_comb begin
        empty = 1'b1;
        for (int i = 0; i < RD_LATENCY - 1; i++) begin
            if (v_q[i]) begin
                empty = 1'b0;
            end
        end
    end

endmodule

// File: rtl/avalon_burst_mem_bridge.sv
// Avalon-MM slave to word-wide backend RAM bridge with read-burst sequencing.
// Optional perf counters: define AVALON_MEM_BRIDGE_STATS_EN.
module avalon_burst_mem_bridge
    import avalon_mem_bridge_pkg::*;
#(
    parameter int RD_LATENCY = 2,
    parameter int MAX_BURST  = MAX_BURST_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:2] avs_address,
    input  logic [31:0] avs_writedata,
    input  logic [3:0]  avs_byteenable,
    input  logic [3:0]  avs_burstcount,
    input  logic        avs_write,
    input  logic        avs_read,
    output logic        avs_waitrequest,
    output logic        avs_readdatavalid,
    output logic [31:0] avs_readdata,
    output logic [31:2] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    output logic        mem_we,
    output logic        mem_re,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic [31:0] stat_rd_beats,
    output logic [31:0] stat_wr_beats,
    output logic [31:0] stat_stall_cycles
);

    state_e      state_q;
    state_e      state_d;
    logic [31:2] addr_q;
    logic [31:2] addr_d;
    logic [3:0]  rem_q;
    logic [3:0]  rem_d;
    logic [3:0]  burst_len;
    logic        pipe_valid;
    logic        pipe_empty;

    assign avs_waitrequest = rst | ~(state_q == IDLE & mem_ready);
    assign mem_wdata       = avs_writedata;
    assign burst_len       = sat_burst(avs_burstcount, MAX_BURST);

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        rem_d    = rem_q;
        mem_we   = 1'b0;
        mem_re   = 1'b0;
        mem_addr = addr_q;
        mem_be   = 4'hF;
        if (!rst) begin
            unique case (state_q)
                IDLE: begin
                    mem_addr = avs_address;
                    if (mem_ready && avs_write) begin
                        mem_we = 1'b1;
                        mem_be = avs_byteenable;
                    end else if (mem_ready && avs_read) begin
                        mem_re  = 1'b1;
                        addr_d  = avs_address + 30'd1;
                        rem_d   = burst_len - 4'd1;
                        state_d = (burst_len > 4'd1) ? READ : DRAIN;
                    end
                end
                READ: begin
                    mem_re = 1'b1;
                    if (mem_ready) begin
                        addr_d = addr_q + 30'd1;
                        rem_d  = rem_q - 4'd1;
                        if (rem_q == 4'd1) begin
                            state_d = DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (pipe_empty) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
        end
    end

    avalon_rd_latency_pipe #(
        .RD_LATENCY(RD_LATENCY)
    ) u_pipe (
        .clk  (clk),
        .rst  (rst),
        .load (mem_re & mem_ready),
        .valid(pipe_valid),
        .empty(pipe_empty)
    );

    // Beats still in the pipe when reset hits are dropped.
    assign avs_readdatavalid = pipe_valid & ~rst;
    assign avs_readdata      = mem_rdata;

`ifdef AVALON_MEM_BRIDGE_STATS_EN
    logic [31:0] rd_cnt_q;
    logic [31:0] rd_cnt_d;
    logic [31:0] wr_cnt_q;
    logic [31:0] wr_cnt_d;
    logic [31:0] stall_cnt_q;
    logic [31:0] stall_cnt_d;
    logic        pending;

    always_comb begin
        pending = (state_q == IDLE && (avs_read || avs_write))
                  || state_q == READ;
        rd_cnt_d    = rd_cnt_q + {31'd0, avs_readdatavalid};
        wr_cnt_d    = wr_cnt_q + {31'd0, mem_we & mem_ready};
        stall_cnt_d = stall_cnt_q
                      + {31'd0, pending & ~mem_ready & ~rst};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_cnt_q    <= '0;
            wr_cnt_q    <= '0;
            stall_cnt_q <= '0;
        end else begin
            rd_cnt_q    <= rd_cnt_d;
            wr_cnt_q    <= wr_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stat_rd_beats     = rd_cnt_q;
    assign stat_wr_beats     = wr_cnt_q;
    assign stat_stall_cycles = stall_cnt_q;
`else
    assign stat_rd_beats     = '0;
    assign stat_wr_beats     = '0;
    assign stat_stall_cycles = '0;
`endif

endmodule

// File: tb/tb_avalon_burst_mem_bridge.sv
// Self-checking bench for avalon_burst_mem_bridge: directed steps plus
// randomized writes/bursts against a reference memory and timing model.
module tb_avalon_burst_mem_bridge;

    localparam int L = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:2] avs_address;
    logic [31:0] avs_writedata;
    logic [3:0]  avs_byteenable;
    logic [3:0]  avs_burstcount;
    logic        avs_write;
    logic        avs_read;
    logic        avs_waitrequest;
    logic        avs_readdatavalid;
    logic [31:0] avs_readdata;
    logic [31:2] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_we;
    logic        mem_re;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic [31:0] stat_rd_beats;
    logic [31:0] stat_wr_beats;
    logic [31:0] stat_stall_cycles;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    avalon_burst_mem_bridge #(
        .RD_LATENCY(L),
        .MAX_BURST (8)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .avs_address      (avs_address),
        .avs_writedata    (avs_writedata),
        .avs_byteenable   (avs_byteenable),
        .avs_burstcount   (avs_burstcount),
        .avs_write        (avs_write),
        .avs_read         (avs_read),
        .avs_waitrequest  (avs_waitrequest),
        .avs_readdatavalid(avs_readdatavalid),
        .avs_readdata     (avs_readdata),
        .mem_addr         (mem_addr),
        .mem_wdata        (mem_wdata),
        .mem_be           (mem_be),
        .mem_we           (mem_we),
        .mem_re           (mem_re),
        .mem_ready        (mem_ready),
        .mem_rdata        (mem_rdata),
        .stat_rd_beats    (stat_rd_beats),
        .stat_wr_beats    (stat_wr_beats),
        .stat_stall_cycles(stat_stall_cycles)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pat(input logic [29:0] a);
        return {a, 2'b01} ^ 32'h5A3C_96E1;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old,
                                          input logic [31:0] nw,
                                          input logic [3:0]  be);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) begin
            r[i*8 +: 8] = be[i] ? nw[i*8 +: 8] : old[i*8 +: 8];
        end
        return r;
    endfunction

    function automatic int exp_len(input logic [3:0] bc);
        if (bc == 4'd0) return 1;
        if (bc > 4'd8) return 8;
        return int'(bc);
    endfunction

    // Backend model: fixed-latency RAM fed by requests seen each cycle.
    logic [31:0] bk_mem [logic [29:0]];
    logic [31:0] dl [0:3];
    logic        cap_re = 1'b0;
    logic        cap_we = 1'b0;
    logic [29:0] cap_addr;
    logic [31:0] cap_wd;
    logic [3:0]  cap_be;

    always @(posedge clk) begin
        logic [31:0] old;
        for (int i = 3; i > 0; i--) dl[i] = dl[i-1];
        if (cap_re) begin
            dl[0] = bk_mem.exists(cap_addr) ? bk_mem[cap_addr] : pat(cap_addr);
        end else begin
            dl[0] = $urandom;
        end
        if (cap_we) begin
            old = bk_mem.exists(cap_addr) ? bk_mem[cap_addr] : pat(cap_addr);
            bk_mem[cap_addr] = merge(old, cap_wd, cap_be);
        end
        mem_rdata = dl[L-1];
        cap_re = 1'b0;
        cap_we = 1'b0;
    end

    // Reference memory and in-order scoreboard of addresses and beats.
    logic [31:0] ref_mem [logic [29:0]];
    logic [29:0] exp_addr [$];
    logic [31:0] exp_data [$];

    always @(negedge clk) begin
        logic [29:0] a;
        logic [31:0] old;
        int          n;
        cap_re   = mem_re && mem_ready;
        cap_we   = mem_we && mem_ready;
        cap_addr = mem_addr;
        cap_wd   = mem_wdata;
        cap_be   = mem_be;
        if (rst) begin
            chk("rst_quiet", {28'd0, avs_waitrequest, avs_readdatavalid,
                              mem_we, mem_re}, 32'h8);
            exp_addr.delete();
            exp_data.delete();
        end else begin
            if (avs_write && !avs_waitrequest) begin
                a   = avs_address;
                old = ref_mem.exists(a) ? ref_mem[a] : pat(a);
                ref_mem[a] = merge(old, avs_writedata, avs_byteenable);
            end else if (avs_read && !avs_waitrequest) begin
                n = exp_len(avs_burstcount);
                for (int i = 0; i < n; i++) begin
                    a = avs_address + 30'(i);
                    exp_addr.push_back(a);
                    exp_data.push_back(ref_mem.exists(a) ? ref_mem[a] : pat(a));
                end
            end
            if (cap_re) begin
                chk("re_queued", 32'(exp_addr.size() > 0), 32'd1);
                if (exp_addr.size() > 0) begin
                    chk("re_addr", 32'(cap_addr), 32'(exp_addr.pop_front()));
                end
            end
            if (avs_readdatavalid) begin
                chk("rv_waitreq", 32'(avs_waitrequest), 32'd1);
                chk("rv_queued", 32'(exp_data.size() > 0), 32'd1);
                if (exp_data.size() > 0) begin
                    chk("rv_data", avs_readdata, exp_data.pop_front());
                end
            end
        end
    end

    task automatic do_write(input logic [29:0] a, input logic [31:0] d,
                            input logic [3:0] be);
        avs_address    = a;
        avs_writedata  = d;
        avs_byteenable = be;
        avs_write      = 1'b1;
        avs_read       = 1'b0;
        mem_ready      = 1'b1;
        @(negedge clk);
        chk("wr_wait", 32'(avs_waitrequest), 32'd0);
        chk("wr_we", 32'(mem_we), 32'd1);
        chk("wr_re", 32'(mem_re), 32'd0);
        chk("wr_addr", 32'(mem_addr), 32'(a));
        chk("wr_be", 32'(mem_be), 32'(be));
        chk("wr_data", mem_wdata, d);
        @(posedge clk);
        #1;
        avs_write = 1'b0;
    endtask

    // sm bit c pulls mem_ready low in cycle c (cycle 0 is the accept).
    task automatic burst(input logic [29:0] a, input logic [3:0] bc,
                         input logic [31:0] sm);
        logic [31:0] re_v, dv_v, wt_v, re_e, dv_e, wt_e;
        int n, issued, last;
        n = exp_len(bc);
        issued = 0;
        last = 0;
        re_e = '0;
        dv_e = '0;
        for (int c = 0; c < 32; c++) begin
            if (issued < n && !sm[c]) begin
                re_e[c]   = 1'b1;
                dv_e[c+L] = 1'b1;
                issued++;
                last = c;
            end
        end
        for (int c = 0; c < 32; c++) begin
            wt_e[c] = !((c == 0 || c >= last + L + 1) && !sm[c]);
        end
        avs_address    = a;
        avs_burstcount = bc;
        avs_read       = 1'b1;
        avs_write      = 1'b0;
        mem_ready      = 1'b1;
        for (int c = 0; c < 32; c++) begin
            @(negedge clk);
            re_v[c] = mem_re && mem_ready;
            dv_v[c] = avs_readdatavalid;
            wt_v[c] = avs_waitrequest;
            @(posedge clk);
            #1;
            avs_read  = 1'b0;
            mem_ready = (c < 31) ? !sm[c+1] : 1'b1;
        end
        mem_ready = 1'b1;
        chk("burst_issue", re_v, re_e);
        chk("burst_valid", dv_v, dv_e);
        chk("burst_wait", wt_v, wt_e);
    endtask

    initial begin
        logic [31:0] sm;
        logic [29:0] ra;
        int          nv;
        int          nre;
        rst            = 1'b1;
        avs_address    = '0;
        avs_writedata  = '0;
        avs_byteenable = '0;
        avs_burstcount = '0;
        avs_write      = 1'b0;
        avs_read       = 1'b0;
        mem_ready      = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_rd_beats", stat_rd_beats, 32'd0);
        chk("rst_wr_beats", stat_wr_beats, 32'd0);
        chk("rst_stalls", stat_stall_cycles, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        do_write(30'h400, 32'hDEAD_BEEF, 4'b0110);
        do_write(30'h803, 32'h1234_5678, 4'hF);
        do_write(30'h805, 32'hCAFE_F00D, 4'b0011);
        burst(30'h800, 4'd8, 32'h0);

        burst(30'h3FFF_FFFF, 4'd3, 32'h6);

        avs_address    = 30'h900;
        avs_writedata  = 32'h0BAD_CAFE;
        avs_byteenable = 4'hF;
        avs_burstcount = 4'd4;
        avs_write      = 1'b1;
        avs_read       = 1'b1;
        @(negedge clk);
        chk("prio_wait", 32'(avs_waitrequest), 32'd0);
        chk("prio_we", 32'(mem_we), 32'd1);
        chk("prio_re", 32'(mem_re), 32'd0);
        @(posedge clk);
        #1;
        avs_write = 1'b0;
        burst(30'h900, 4'd4, 32'h0);

        burst(30'hA00, 4'd0, 32'h0);
        burst(30'hA10, 4'd12, 32'h0);

        avs_address    = 30'hB00;
        avs_burstcount = 4'd8;
        avs_read       = 1'b1;
        mem_ready      = 1'b1;
        @(negedge clk);
        chk("rb_accept", 32'(avs_waitrequest), 32'd0);
        @(posedge clk);
        #1;
        avs_read = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rb_release_wait", 32'(avs_waitrequest), 32'd0);
        nv  = 0;
        nre = 0;
        repeat (8) begin
            @(negedge clk);
            nv  += int'(avs_readdatavalid);
            nre += int'(mem_re);
        end
        chk("rb_no_valid", 32'(nv), 32'd0);
        chk("rb_no_issue", 32'(nre), 32'd0);
        @(posedge clk);
        #1;

        for (int it = 0; it < 24; it++) begin
            ra = 30'hC00 + 30'($urandom_range(0, 15));
            if ($urandom_range(0, 2) == 0) begin
                do_write(ra, $urandom, 4'($urandom));
            end else begin
                sm = '0;
                for (int b = 1; b <= 12; b++) begin
                    sm[b] = ($urandom_range(0, 3) == 0);
                end
                burst(ra, 4'($urandom), sm);
            end
        end

        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        do_write(30'hD00, 32'h1111_1111, 4'hF);
        do_write(30'hD01, 32'h2222_2222, 4'hF);
        do_write(30'hD02, 32'h3333_3333, 4'h1);
        do_write(30'hD03, 32'h4444_4444, 4'h8);
        burst(30'hD00, 4'd8, 32'hEC);
        @(negedge clk);
`ifdef AVALON_MEM_BRIDGE_STATS_EN
        chk("stat_rd", stat_rd_beats, 32'd8);
        chk("stat_wr", stat_wr_beats, 32'd4);
        chk("stat_stall", stat_stall_cycles, 32'd5);
`else
        chk("stat_rd", stat_rd_beats, 32'd0);
        chk("stat_wr", stat_wr_beats, 32'd0);
        chk("stat_stall", stat_stall_cycles, 32'd0);
`endif
        chk("end_drained", 32'(exp_data.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
